// File: rtl/screen_saver_pkg.sv
// Shared types and constants for the screen-saver playback controller.
package screen_saver_pkg;

    typedef enum logic [1:0] {
        SOUND_ANIM0 = 2'd0,
        SOUND_ANIM1 = 2'd1,
        SOUND_ANIM2 = 2'd2,
        SOUND_PASS  = 2'd3
    } sound_t;

    typedef logic [2:0] speed_t;

    localparam speed_t SPEED_RESET = 3'd2;
    localparam speed_t SPEED_MAX   = 3'd4;

    // Button roles by key_n bit index.
    localparam int KEY_FAST = 0;
    localparam int KEY_NEXT = 1;
    localparam int KEY_BACK = 2;
    localparam int KEY_SLOW = 3;

    localparam int unsigned MAXCNT_SPEED0  = 200_000_000;
    localparam int unsigned MAXCNT_SPEED1  = 100_000_000;
    localparam int unsigned MAXCNT_SPEED2  = 50_000_000;
    localparam int unsigned MAXCNT_SPEED3  = 25_000_000;
    localparam int unsigned MAXCNT_SPEED4  = 1_250_000;
    localparam int unsigned MAXCNT_DEFAULT = 50_000_000;

endpackage

// File: rtl/key_pulse.sv
// Rising-edge detector: one registered single-cycle pulse per 0->1 transition of in.
module key_pulse (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);

    logic prev_q, prev_d;
    logic out_q, out_d;

    always_comb begin
        prev_d = in;
        out_d  = in & ~prev_q;
    end

    // NOTE: state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
            out_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            out_q  <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/de1_soc_top.sv
// Screen-saver playback controller: buttons -> sound/speed selection, pixel/audio muxes.
// Define AUDIO_PASSTHROUGH_EN to make sound index 3 (codec capture passthrough) reachable.
module de1_soc_top
    import screen_saver_pkg::*;
#(
    parameter int COORD_W = 11,
    parameter int AUDIO_W = 24,
    parameter int CNT_W   = 28
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [3:0]                key_n,
    input  logic [COORD_W-1:0]        an0_x,
    input  logic [COORD_W-1:0]        an1_x,
    input  logic [COORD_W-1:0]        an2_x,
    input  logic [COORD_W-1:0]        an0_y,
    input  logic [COORD_W-1:0]        an1_y,
    input  logic [COORD_W-1:0]        an2_y,
    input  logic                      color0,
    input  logic                      color1,
    input  logic                      color2,
    input  logic signed [AUDIO_W-1:0] anim0_left,
    input  logic signed [AUDIO_W-1:0] anim1_left,
    input  logic signed [AUDIO_W-1:0] anim2_left,
    input  logic signed [AUDIO_W-1:0] anim0_right,
    input  logic signed [AUDIO_W-1:0] anim1_right,
    input  logic signed [AUDIO_W-1:0] anim2_right,
    input  logic signed [AUDIO_W-1:0] readdata_left,
    input  logic signed [AUDIO_W-1:0] readdata_right,
    input  logic                      read_ready,
    input  logic                      write_ready,
    output logic [COORD_W-1:0]        x,
    output logic [COORD_W-1:0]        y,
    output logic                      color,
    output logic signed [AUDIO_W-1:0] writedata_left,
    output logic signed [AUDIO_W-1:0] writedata_right,
    output logic                      read,
    output logic                      write,
    output logic                      rd_wr_en,
    output logic [1:0]                sound,
    output logic [2:0]                speed,
    output logic [CNT_W-1:0]          max_counter
);

    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;
    logic [3:0] arm_q, arm_d;
    logic [1:0] settle_q, settle_d;
    logic [3:0] pulse;
    sound_t     sound_q, sound_d;
    speed_t     speed_q, speed_d;
    logic       go_next, go_back, go_fast, go_slow;

    // A key is armed only once it has been seen released with the synchroniser
    // holding post-reset data, so a key held through reset cannot fire.
    always_comb begin
        sync1_d  = ~key_n;
        sync2_d  = sync1_q;
        settle_d = {settle_q[0], 1'b1};
        arm_d    = arm_q | ({4{settle_q[1]}} & ~sync2_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            arm_q    <= '0;
            settle_q <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            arm_q    <= arm_d;
            settle_q <= settle_d;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_pulse u_key_pulse (
            .clk   (clk),
            .reset (reset),
            .in    (sync2_q[i] & arm_q[i]),
            .out   (pulse[i])
        );
    end

    assign go_next = pulse[KEY_NEXT] & ~pulse[KEY_BACK];
    assign go_back = pulse[KEY_BACK] & ~pulse[KEY_NEXT];
    assign go_fast = pulse[KEY_FAST] & ~pulse[KEY_SLOW];
    assign go_slow = pulse[KEY_SLOW] & ~pulse[KEY_FAST];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sound_d = sound_q;
        if (go_next) begin
            unique case (sound_q)
                SOUND_ANIM0: sound_d = SOUND_ANIM1;
                SOUND_ANIM1: sound_d = SOUND_ANIM2;
                SOUND_ANIM2: sound_d = SOUND_ANIM0;
                SOUND_PASS:  sound_d = SOUND_ANIM0;
            endcase
        end else if (go_back) begin
            unique case (sound_q)
`ifdef AUDIO_PASSTHROUGH_EN
                SOUND_ANIM0: sound_d = SOUND_PASS;
`else
                SOUND_ANIM0: sound_d = SOUND_ANIM2;
`endif
                SOUND_ANIM1: sound_d = SOUND_ANIM0;
                SOUND_ANIM2: sound_d = SOUND_ANIM1;
                SOUND_PASS:  sound_d = SOUND_ANIM2;
            endcase
        end

        speed_d = speed_q;
        if (go_fast && speed_q < SPEED_MAX) begin
            speed_d = speed_q + 3'd1;
        end else if (go_slow && speed_q > 3'd0) begin
            speed_d = speed_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sound_q <= SOUND_ANIM0;
            speed_q <= SPEED_RESET;
        end else begin
            sound_q <= sound_d;
            speed_q <= speed_d;
        end
    end

    always_comb begin
        unique case (speed_q)
            3'd0:    max_counter = CNT_W'(MAXCNT_SPEED0);
            3'd1:    max_counter = CNT_W'(MAXCNT_SPEED1);
            3'd2:    max_counter = CNT_W'(MAXCNT_SPEED2);
            3'd3:    max_counter = CNT_W'(MAXCNT_SPEED3);
            3'd4:    max_counter = CNT_W'(MAXCNT_SPEED4);
            default: max_counter = CNT_W'(MAXCNT_DEFAULT);
        endcase
    end

    // Sound 3 reuses animation 2 visuals while the codec capture is played back.
    always_comb begin
        x     = an2_x;
        y     = an2_y;
        color = color2;
        if (sound_q == SOUND_ANIM0) begin
            x     = an0_x;
            y     = an0_y;
            color = color0;
        end else if (sound_q == SOUND_ANIM1) begin
            x     = an1_x;
            y     = an1_y;
            color = color1;
        end
    end

    always_comb begin
        unique case (sound_q)
            SOUND_ANIM0: begin
                writedata_left  = anim0_left;
                writedata_right = anim0_right;
            end
            SOUND_ANIM1: begin
                writedata_left  = anim1_left;
                writedata_right = anim1_right;
            end
            SOUND_ANIM2: begin
                writedata_left  = anim2_left;
                writedata_right = anim2_right;
            end
            SOUND_PASS: begin
                writedata_left  = readdata_left;
                writedata_right = readdata_right;
            end
        endcase
    end

    assign read     = read_ready & write_ready;
    assign write    = read_ready & write_ready;
    assign rd_wr_en = read_ready & write_ready;

    assign sound = sound_q;
    assign speed = speed_q;

endmodule

// File: tb/tb_de1_soc_top.sv
// Self-checking bench for de1_soc_top: event-level model of button effects plus directed checks.
module tb_de1_soc_top;

    localparam int COORD_W = 11;
    localparam int AUDIO_W = 24;
    localparam int CNT_W   = 28;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [3:0]          key_n = 4'hF;
    logic [COORD_W-1:0]  an0_x, an1_x, an2_x, an0_y, an1_y, an2_y;
    logic                color0, color1, color2;
    logic [AUDIO_W-1:0]  anim0_left, anim1_left, anim2_left;
    logic [AUDIO_W-1:0]  anim0_right, anim1_right, anim2_right;
    logic [AUDIO_W-1:0]  readdata_left, readdata_right;
    logic                read_ready, write_ready;
    logic [COORD_W-1:0]  x, y;
    logic                color;
    logic [AUDIO_W-1:0]  writedata_left, writedata_right;
    logic                read, write, rd_wr_en;
    logic [1:0]          sound;
    logic [2:0]          speed;
    logic [CNT_W-1:0]    max_counter;

    always #5 clk = ~clk;

    de1_soc_top #(.COORD_W(COORD_W), .AUDIO_W(AUDIO_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .key_n(key_n),
        .an0_x(an0_x), .an1_x(an1_x), .an2_x(an2_x),
        .an0_y(an0_y), .an1_y(an1_y), .an2_y(an2_y),
        .color0(color0), .color1(color1), .color2(color2),
        .anim0_left(anim0_left), .anim1_left(anim1_left), .anim2_left(anim2_left),
        .anim0_right(anim0_right), .anim1_right(anim1_right), .anim2_right(anim2_right),
        .readdata_left(readdata_left), .readdata_right(readdata_right),
        .read_ready(read_ready), .write_ready(write_ready),
        .x(x), .y(y), .color(color),
        .writedata_left(writedata_left), .writedata_right(writedata_right),
        .read(read), .write(write), .rd_wr_en(rd_wr_en),
        .sound(sound), .speed(speed), .max_counter(max_counter)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A press sampled low at edge k (after a high sample, key armed) takes effect at edge k+3.
    int         cyc = 0;
    logic [3:0] pend [4];
    bit         armed [4];
    bit         prev_high [4];
    int         m_sound = 0;
    int         m_speed = 2;
    bit         model_ok = 1'b0;
    logic [3:0] m_p;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_sound  = 0;
            m_speed  = 2;
            model_ok = 1'b1;
            for (int i = 0; i < 4; i++) begin
                pend[i]  = 4'b0;
                armed[i] = 1'b0;
            end
        end else begin
            m_p = pend[cyc % 4];
            pend[cyc % 4] = 4'b0;
            if (m_p[1] && !m_p[2]) m_sound = (m_sound >= 2) ? 0 : m_sound + 1;
            else if (m_p[2] && !m_p[1]) begin
`ifdef AUDIO_PASSTHROUGH_EN
                m_sound = (m_sound == 0) ? 3 : m_sound - 1;
`else
                m_sound = (m_sound == 0) ? 2 : m_sound - 1;
`endif
            end
            if (m_p[0] && !m_p[3] && m_speed < 4) m_speed++;
            else if (m_p[3] && !m_p[0] && m_speed > 0) m_speed--;
            for (int i = 0; i < 4; i++) begin
                if (!key_n[i] && prev_high[i] && armed[i]) pend[(cyc + 3) % 4][i] = 1'b1;
                if (key_n[i]) armed[i] = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) prev_high[i] = key_n[i];
    end

    function automatic logic [63:0] exp_max(input int s);
        case (s)
            0:       return 64'd200_000_000;
            1:       return 64'd100_000_000;
            2:       return 64'd50_000_000;
            3:       return 64'd25_000_000;
            4:       return 64'd1_250_000;
            default: return 64'd50_000_000;
        endcase
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_ok) begin
            check("sound", 64'(sound), 64'(m_sound));
            check("speed", 64'(speed), 64'(m_speed));
            check("max_counter", 64'(max_counter), exp_max(m_speed));
            check("x", 64'(x), 64'(m_sound == 0 ? an0_x : m_sound == 1 ? an1_x : an2_x));
            check("y", 64'(y), 64'(m_sound == 0 ? an0_y : m_sound == 1 ? an1_y : an2_y));
            check("color", 64'(color), 64'(m_sound == 0 ? color0 : m_sound == 1 ? color1 : color2));
            check("wd_left", 64'(writedata_left),
                  64'(m_sound == 0 ? anim0_left : m_sound == 1 ? anim1_left :
                      m_sound == 2 ? anim2_left : readdata_left));
            check("wd_right", 64'(writedata_right),
                  64'(m_sound == 0 ? anim0_right : m_sound == 1 ? anim1_right :
                      m_sound == 2 ? anim2_right : readdata_right));
            check("strobes", 64'({read, write, rd_wr_en}), 64'({3{read_ready & write_ready}}));
        end
    end

    // ---------------- random data driver ----------------
    bit rand_en = 1'b0;

    always @(posedge clk) begin
        #1;
        if (rand_en) begin
            an0_x = COORD_W'($urandom); an1_x = COORD_W'($urandom); an2_x = COORD_W'($urandom);
            an0_y = COORD_W'($urandom); an1_y = COORD_W'($urandom); an2_y = COORD_W'($urandom);
            {color0, color1, color2} = 3'($urandom);
            anim0_left  = AUDIO_W'($urandom); anim1_left  = AUDIO_W'($urandom);
            anim2_left  = AUDIO_W'($urandom); anim0_right = AUDIO_W'($urandom);
            anim1_right = AUDIO_W'($urandom); anim2_right = AUDIO_W'($urandom);
            readdata_left  = AUDIO_W'($urandom);
            readdata_right = AUDIO_W'($urandom);
            {read_ready, write_ready} = 2'($urandom);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        key_n = ~mask;
        step(hold);
        key_n = 4'hF;
        step(6);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(5);
    endtask

    int exp_fast [5] = '{3, 4, 4, 4, 4};
    int exp_slow [6] = '{3, 2, 1, 0, 0, 0};

    initial begin
        an0_x = 11'd5;  an1_x = 11'd6;  an2_x = 11'd7;
        an0_y = 11'd15; an1_y = 11'd16; an2_y = 11'd17;
        {color0, color1, color2} = 3'b100;
        anim0_left = 24'd100; anim1_left = 24'd101; anim2_left = 24'd102;
        anim0_right = 24'd200; anim1_right = 24'd201; anim2_right = 24'd202;
        readdata_left = 24'd300; readdata_right = 24'd301;
        read_ready = 1'b0; write_ready = 1'b0;
        step(2);

        // Reset state.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("rst_sound", 64'(sound), 64'd0);
        check("rst_speed", 64'(speed), 64'd2);
        check("rst_max", 64'(max_counter), 64'd50_000_000);
        check("rst_x", 64'(x), 64'd5);
        check("rst_y", 64'(y), 64'd15);
        step(5);

        // Long hold: exactly one step, landing on the 4th edge.
        key_n[1] = 1'b0;
        step(3);
        check("hold_edge3", 64'(sound), 64'd0);
        step(1);
        check("hold_edge4", 64'(sound), 64'd1);
        step(16);
        check("hold_once", 64'(sound), 64'd1);
        key_n[1] = 1'b1;
        step(6);
        press(4'b0010, 4); check("next_2", 64'(sound), 64'd2);
        press(4'b0010, 4); check("next_wrap", 64'(sound), 64'd0);
        press(4'b0010, 4); check("next_1", 64'(sound), 64'd1);
        press(4'b0010, 4);
        press(4'b0010, 4); check("back_pre", 64'(sound), 64'd0);

        // Back from sound 0.
        press(4'b0100, 4);
`ifdef AUDIO_PASSTHROUGH_EN
        check("back_wrap", 64'(sound), 64'd3);
        check("pass_left", 64'(writedata_left), 64'd300);
        check("pass_x", 64'(x), 64'd7);
        press(4'b0100, 4);
`endif
        check("back_to_2", 64'(sound), 64'd2);
        an2_x = 11'd3; anim2_left = 24'd3;
        #1;
        check("mux_x", 64'(x), 64'd3);
        check("mux_left", 64'(writedata_left), 64'd3);
        step(1);

        // Speed limits.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            press(4'b0001, 4);
            check("fast", 64'(speed), 64'(exp_fast[i]));
        end
        check("max_fast", 64'(max_counter), 64'd1_250_000);
        for (int i = 0; i < 6; i++) begin
            press(4'b1000, 4);
            check("slow", 64'(speed), 64'(exp_slow[i]));
        end
        check("max_slow", 64'(max_counter), 64'd200_000_000);

        // Codec strobes.
        read_ready = 1'b1; write_ready = 1'b0;
        #1;
        check("strobe_off", 64'({read, write, rd_wr_en}), 64'd0);
        write_ready = 1'b1;
        #1;
        check("strobe_on", 64'({read, write, rd_wr_en}), 64'd7);
        step(1);

        // Simultaneous next/back, then reset during a hold.
        do_reset();
        press(4'b0010, 4);
        press(4'b0110, 4);
        check("next_back_hold", 64'(sound), 64'd1);
        key_n[1] = 1'b0;
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("mid_hold_rst", 64'(sound), 64'd0);
        step(20);
        check("held_no_pulse", 64'(sound), 64'd0);
        key_n[1] = 1'b1;
        step(6);
        press(4'b0010, 4);
        check("repress", 64'(sound), 64'd1);

        // Randomised presses, overlaps and occasional resets against the model.
        rand_en = 1'b1;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(29) == 0) begin
                do_reset();
            end else begin
                logic [3:0] mask;
                mask = 4'($urandom);
                if (mask == 4'b0) mask = 4'b0010;
                key_n = ~mask;
                step($urandom_range(6, 3));
                key_n = 4'hF;
                step($urandom_range(8, 3));
            end
        end
        rand_en = 1'b0;
        step(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
